// File: rtl/serial_pkg.sv
// Shared definitions for the odd-parity serial link (transmitter and receiver).
//   tx_state_e  : 4-bit FSM state encodings for the transmitter
//   FRAME_BITS  : START + 8 data + PARITY + STOP
//   DATA_BITS   : payload width of one frame
//   odd_parity(): parity bit that makes data+parity carry an odd number of ones
package serial_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DATA   = 4'd2,
        ST_PARITY = 4'd3,
        ST_STOP   = 4'd4
    } tx_state_e;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO in front of the serial transmitter.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push_i / din_i  : write one entry (ignored while full)
//   pop_i / dout_o  : dout_o shows the head entry (first-word fall-through);
//                     pop_i retires it (ignored while empty)
//   full_o, empty_o : occupancy flags
//   count_o         : occupancy, 0..DEPTH
// Push and pop on the same edge leave the count unchanged.
module tx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/serial_transmitter_parity.sv
// Serial transmitter with odd parity and an input byte FIFO.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid, in_byte : upstream byte; accepted when in_valid && in_ready
//   in_ready          : FIFO not full
//   err_inj           : sampled when a byte is popped; inverts that frame's parity
//   o_data            : registered serial line, idle high
//   busy              : FSM outside IDLE
//   frame_done        : one-cycle pulse while STOP is on the line
//   fifo_count        : FIFO occupancy
// Frame: START(0), D0..D7 LSB first, PARITY, STOP(1); one bit per clock.
module serial_transmitter_parity
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_byte,
    output logic                          in_ready,
    input  logic                          err_inj,
    output logic                          o_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q;
    logic [2:0]           bit_cnt_q;
    logic [2:0]           bit_nxt;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic                 o_data_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_cnt;
    logic                 push;
    logic                 load;

    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    // A new frame starts from IDLE, or straight out of STOP so back-to-back
    // frames have no idle gap.
    assign load       = ((state_q == ST_IDLE) || (state_q == ST_STOP)) && !fifo_empty;
    assign bit_nxt    = bit_cnt_q + 3'd1;

    assign o_data     = o_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign fifo_count = fifo_cnt;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .din_i   (in_byte),
        .pop_i   (load),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Outputs are registered alongside the state: each branch drives the
    // line value that belongs to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            o_data_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (load) begin
                // Byte and err_inj are captured here, so later changes on
                // the inputs cannot disturb the frame in flight.
                state_q   <= ST_START;
                data_q    <= fifo_dout;
                par_q     <= odd_parity(fifo_dout) ^ err_inj;
                bit_cnt_q <= '0;
                o_data_q  <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        o_data_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    ST_START: begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                        o_data_q  <= data_q[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt_q == 3'd7) begin
                            state_q   <= ST_PARITY;
                            bit_cnt_q <= '0;
                            o_data_q  <= par_q;
                        end else begin
                            bit_cnt_q <= bit_nxt;
                            o_data_q  <= data_q[bit_nxt];
                        end
                    end
                    ST_PARITY: begin
                        state_q      <= ST_STOP;
                        o_data_q     <= 1'b1;
                        frame_done_q <= 1'b1;
                    end
                    ST_STOP: begin
                        state_q  <= ST_IDLE;
                        o_data_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        o_data_q  <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_transmitter_parity.sv
module tb_serial_transmitter_parity;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       err_inj;
    logic       o_data;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    serial_transmitter_parity #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .err_inj    (err_inj),
        .o_data     (o_data),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [7:0] b;
        logic       err;
        logic       par;   // expected parity bit on the line
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       done;  // receiver would accept the frame
    } sb_t;

    sb_t        sb[$];
    vec_t       tbl[10];
    int         checks = 0;
    int         errors = 0;
    logic [10:0] hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Independent parity reference: count the ones.
    function automatic logic ref_par(input logic [7:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(b[i]);
        return (n % 2 == 0);
    endfunction

    // Loopback receiver model: rebuilds each frame from the line and
    // compares it against the scoreboard head when STOP is on the line.
    task automatic monitor();
        logic [7:0] rx;
        logic       rx_done;
        sb_t        e;
        forever begin
            @(negedge clk);
            hist = {hist[9:0], o_data};
            if (frame_done === 1'b1) begin
                for (int i = 0; i < 8; i++) rx[i] = hist[9-i];
                rx_done = (^{rx, hist[1]}) & hist[0] & ~hist[10];
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got byte %0h expected none", rx);
                end else begin
                    e = sb.pop_front();
                    check("start_bit", {31'd0, hist[10]}, 32'd0);
                    check("rx_byte", {24'd0, rx}, {24'd0, e.b});
                    check("parity_bit", {31'd0, hist[1]}, {31'd0, e.par});
                    check("rx_done", {31'd0, rx_done}, {31'd0, e.done});
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_count != 3'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (n < budget)}, 32'd1);
    endtask

    // Single frame from idle: err_inj is held through the pop edge, then
    // inputs are scrambled while the frame is on the line.
    task automatic push_one(input logic [7:0] b, input logic err, input logic par);
        in_valid = 1'b1;
        in_byte  = b;
        err_inj  = err;
        sb.push_back('{b, par, ~err});
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = ~b;
        @(negedge clk);
        err_inj  = ~err;
        wait_idle("tbl_idle", 40);
        err_inj  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] exp_frame;
        logic [6:0]  exp_acc;
        int          bc, nfd, n, bad, sent;
        logic [7:0]  r;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        err_inj  = 1'b0;
        hist     = '1;

        tbl[0] = '{8'hA5, 1'b0, 1'b1};
        tbl[1] = '{8'h00, 1'b0, 1'b1};
        tbl[2] = '{8'h07, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 1'b0};
        tbl[4] = '{8'h3C, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h80, 1'b0, 1'b0};
        tbl[7] = '{8'hFE, 1'b1, 1'b1};
        tbl[8] = '{8'h55, 1'b0, 1'b1};
        tbl[9] = '{8'h01, 1'b0, 1'b0};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_data", {31'd0, o_data}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 0xA5 bit-exact frame, latency and busy width
        exp_frame = 11'b01010010111;
        in_valid  = 1'b1;
        in_byte   = 8'hA5;
        sb.push_back('{8'hA5, 1'b1, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'h5A;
        check("no_bypass_o_data", {31'd0, o_data}, 32'd1);
        check("count_after_push", {29'd0, fifo_count}, 32'd1);
        bc = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check("a5_line_bit", {31'd0, o_data}, {31'd0, exp_frame[10-k]});
            check("a5_frame_done", {31'd0, frame_done}, {31'd0, (k == 10)});
            bc += int'(busy);
        end
        @(negedge clk);
        check("a5_busy_cycles", bc, 11);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        check("a5_idle_line", {31'd0, o_data}, 32'd1);

        // Table of single frames (includes err_inj cases)
        for (int i = 0; i < 10; i++) push_one(tbl[i].b, tbl[i].err, tbl[i].par);

        // Back-to-back 0x00, 0x07: one unbroken 22-cycle busy window
        in_valid = 1'b1;
        in_byte  = 8'h00;
        sb.push_back('{8'h00, 1'b1, 1'b1});
        @(negedge clk);
        in_byte  = 8'h07;
        sb.push_back('{8'h07, 1'b0, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        bc = 0; nfd = 0; n = 0;
        while (n < 100) begin
            if (busy) begin
                bc++;
                nfd += int'(frame_done);
            end else if (bc > 0) break;
            @(negedge clk);
            n++;
        end
        check("b2b_busy_cycles", bc, 22);
        check("b2b_frame_dones", nfd, 2);

        // Overflow: FIFO fills to DEPTH while first frame runs
        exp_acc = 7'b0011111;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h10 + 8'(i);
            check("ovf_in_ready", {31'd0, in_ready}, {31'd0, exp_acc[i]});
            check("ovf_ready_vs_count", {31'd0, in_ready}, {31'd0, (fifo_count < 3'd4)});
            if (in_ready) sb.push_back('{in_byte, ref_par(in_byte), 1'b1});
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("ovf_full_count", {29'd0, fifo_count}, 32'd4);
        wait_idle("ovf_drain", 200);
        @(negedge clk);

        // Reset during D4 of 0xFF with two bytes queued
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        sb.push_back('{8'hFF, 1'b1, 1'b1});
        @(negedge clk);
        in_byte = 8'h11;
        @(negedge clk);
        in_byte = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("d4_busy", {31'd0, busy}, 32'd1);
        check("d4_queued", {29'd0, fifo_count}, 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_o_data", {31'd0, o_data}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_frame_done", {31'd0, frame_done}, 32'd0);
        check("arst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || o_data !== 1'b1 || fifo_count !== 3'd0) bad++;
        end
        check("no_frame_after_rst", bad, 0);

        // Random loopback: 256 clean bytes with random valid gaps
        sent = 0;
        n    = 0;
        while (sent < 256 && n < 20000) begin
            if (in_ready && $urandom_range(0, 3) != 0) begin
                r        = 8'($urandom);
                in_valid = 1'b1;
                in_byte  = r;
                sb.push_back('{r, ref_par(r), 1'b1});
                sent++;
            end else begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("rand_all_sent", sent, 256);
        wait_idle("rand_drain", 5000);
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
